// File: rtl/stream_merge_2to1_rr.sv
// ============================================================================
// stream_merge_2to1_rr
// ----------------------------------------------------------------------------
// Two-input, one-output packet stream merger. It recombines two valid/ready
// streams into a single registered output stream and is the counterpart of
// the 1-to-2 demux stage.
//
// Arbitration is round-robin and happens per packet, not per beat. Once a
// channel wins, it stays locked until the last beat of its packet has been
// accepted. This guarantees that beats from different packets never
// interleave on the output.
//
// Ports
//   clk_in        : clock; all state changes on the rising edge
//   rst_n_in      : synchronous, active-low reset
//   s0_data_in    : channel 0 payload (DATA_W bits)
//   s0_valid_in   : channel 0 beat valid
//   s0_last_in    : channel 0 final beat of packet
//   s0_ready_out  : channel 0 accept strobe (beat taken when high with valid)
//   s1_data_in    : channel 1 payload (DATA_W bits)
//   s1_valid_in   : channel 1 beat valid
//   s1_last_in    : channel 1 final beat of packet
//   s1_ready_out  : channel 1 accept strobe
//   m_data_out    : merged payload, registered
//   m_valid_out   : merged beat valid, registered
//   m_last_out    : merged last flag, registered
//   m_src_out     : source channel of the current output beat, registered
//   m_ready_in    : downstream accepts the current output beat
//
// Latency is one cycle from input accept to m_valid_out. Sustained
// throughput is one beat per cycle while m_ready_in stays high.
// ============================================================================
module stream_merge_2to1_rr #(
    parameter int DATA_W = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,

    input  logic [DATA_W-1:0] s0_data_in,
    input  logic              s0_valid_in,
    input  logic              s0_last_in,
    output logic              s0_ready_out,

    input  logic [DATA_W-1:0] s1_data_in,
    input  logic              s1_valid_in,
    input  logic              s1_last_in,
    output logic              s1_ready_out,

    output logic [DATA_W-1:0] m_data_out,
    output logic              m_valid_out,
    output logic              m_last_out,
    output logic              m_src_out,
    input  logic              m_ready_in
);

    // IDLE  : no packet is open, so the next grant comes from arbitration.
    // LOCK0 : a channel-0 packet is in progress; only channel 0 is served.
    // LOCK1 : a channel-1 packet is in progress; only channel 1 is served.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t            state;
    logic              rr_ptr;     // channel favoured when both request in IDLE

    logic              ld;         // output register may take a new beat
    logic              grant_vld;  // some channel holds the grant this cycle
    logic              grant_ch;   // which channel holds it
    logic              acc0;
    logic              acc1;
    logic              acc;
    logic [DATA_W-1:0] acc_data;
    logic              acc_last;

    // The output register can load when it is empty, or when its current
    // beat leaves this cycle. The second case is what allows back-to-back
    // beats with no bubble.
    assign ld = !m_valid_out || m_ready_in;

    // Grant selection.
    // A locked state forces the grant to the owning channel, whatever the
    // other channel is doing. In IDLE, a lone requester always wins; rr_ptr
    // only breaks ties.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = 1'b0;
        case (state)
            IDLE: begin
                if (s0_valid_in && s1_valid_in) begin
                    grant_vld = 1'b1;
                    grant_ch  = rr_ptr;
                end else if (s0_valid_in) begin
                    grant_vld = 1'b1;
                    grant_ch  = 1'b0;
                end else if (s1_valid_in) begin
                    grant_vld = 1'b1;
                    grant_ch  = 1'b1;
                end
            end
            LOCK0: begin
                grant_vld = 1'b1;
                grant_ch  = 1'b0;
            end
            LOCK1: begin
                grant_vld = 1'b1;
                grant_ch  = 1'b1;
            end
            default: begin
                grant_vld = 1'b0;
                grant_ch  = 1'b0;
            end
        endcase
    end

    // Ready strobes.
    // Both readies are gated with the reset input. Because reset is
    // synchronous, the upstream would otherwise see a live handshake in a
    // cycle whose state update is about to be discarded by the reset edge.
    assign s0_ready_out = rst_n_in && ld && grant_vld && !grant_ch;
    assign s1_ready_out = rst_n_in && ld && grant_vld &&  grant_ch;

    assign acc0     = s0_valid_in && s0_ready_out;
    assign acc1     = s1_valid_in && s1_ready_out;
    assign acc      = acc0 || acc1;
    assign acc_data = grant_ch ? s1_data_in : s0_data_in;
    assign acc_last = grant_ch ? s1_last_in : s0_last_in;

    // Packet FSM, round-robin pointer and output register.
    //
    // Nothing changes while ld is low (output stalled). This is why
    // backpressure freezes the lock state as well as the output beat.
    //
    // rr_ptr moves only when a packet closes, so the fairness unit is the
    // packet. The pointer then favours the channel that was not just served.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            m_data_out  <= '0;
            m_valid_out <= 1'b0;
            m_last_out  <= 1'b0;
            m_src_out   <= 1'b0;
        end else if (ld) begin
            if (acc) begin
                m_data_out  <= acc_data;
                m_last_out  <= acc_last;
                m_src_out   <= grant_ch;
                m_valid_out <= 1'b1;
                if (acc_last) begin
                    state  <= IDLE;
                    rr_ptr <= ~grant_ch;
                end else begin
                    state  <= grant_ch ? LOCK1 : LOCK0;
                end
            end else begin
                m_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_merge_2to1_rr.sv
// ============================================================================
// tb_stream_merge_2to1_rr
// ----------------------------------------------------------------------------
// Directed bench for stream_merge_2to1_rr.
//
// Per-channel beat queues feed a driver process. The expected output order is
// hand-computed and pushed into a scoreboard queue when the stimulus is
// issued. A monitor pops and compares every beat the DUT hands downstream.
// ============================================================================
module tb_stream_merge_2to1_rr;

    localparam int DATA_W = 8;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [DATA_W-1:0] s0_data_in;
    logic              s0_valid_in;
    logic              s0_last_in;
    logic              s0_ready_out;
    logic [DATA_W-1:0] s1_data_in;
    logic              s1_valid_in;
    logic              s1_last_in;
    logic              s1_ready_out;
    logic [DATA_W-1:0] m_data_out;
    logic              m_valid_out;
    logic              m_last_out;
    logic              m_src_out;
    logic              m_ready_in;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              src;
    } exp_t;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];
    int    pop_cycles[$];

    int    checks     = 0;
    int    errors     = 0;
    int    pop_count  = 0;
    int    cycle      = 0;
    bit    lock_phase = 1'b0;

    stream_merge_2to1_rr #(.DATA_W(DATA_W)) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .s0_data_in   (s0_data_in),
        .s0_valid_in  (s0_valid_in),
        .s0_last_in   (s0_last_in),
        .s0_ready_out (s0_ready_out),
        .s1_data_in   (s1_data_in),
        .s1_valid_in  (s1_valid_in),
        .s1_last_in   (s1_last_in),
        .s1_ready_out (s1_ready_out),
        .m_data_out   (m_data_out),
        .m_valid_out  (m_valid_out),
        .m_last_out   (m_last_out),
        .m_src_out    (m_src_out),
        .m_ready_in   (m_ready_in)
    );

    always #5 clk_in = ~clk_in;

    // Cycle counter used to measure output throughput.
    always @(posedge clk_in) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [DATA_W-1:0] data,
                                 input logic last);
        beat_t b;
        b.data = data;
        b.last = last;
        if (ch == 0) q0.push_back(b);
        else         q1.push_back(b);
    endtask

    task automatic expectBeat(input logic [DATA_W-1:0] data, input logic last,
                              input logic src);
        exp_t e;
        e.data = data;
        e.last = last;
        e.src  = src;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) until every expected beat has been seen.
    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: %0d beats outstanding, expected 0",
                     name, exp_q.size());
        end
    endtask

    // Waits (bounded) until the monitor has seen a given number of beats.
    task automatic waitPops(input string name, input int target, input int budget);
        int n = 0;
        while (pop_count < target && n < budget) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        if (pop_count < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: %0d beats seen, expected %0d",
                     name, pop_count, target);
        end
    endtask

    // After a drain, the output must fall quiet: a duplicated or extra beat
    // would show up here.
    task automatic checkIdle(input string name);
        repeat (3) @(negedge clk_in);
        checkOutput(name, {31'd0, m_valid_out}, 32'd0);
    endtask

    // Driver process.
    // A handshake is judged at the negedge, where inputs and readies are
    // stable. The accepted beat is retired just after the following rising
    // edge, and the next queued beat (if any) is presented.
    initial begin
        bit f0;
        bit f1;
        s0_valid_in = 1'b0;
        s0_data_in  = '0;
        s0_last_in  = 1'b0;
        s1_valid_in = 1'b0;
        s1_data_in  = '0;
        s1_last_in  = 1'b0;
        forever begin
            @(negedge clk_in);
            f0 = (s0_valid_in === 1'b1) && (s0_ready_out === 1'b1);
            f1 = (s1_valid_in === 1'b1) && (s1_ready_out === 1'b1);
            @(posedge clk_in);
            #1;
            if (f0 && q0.size() > 0) void'(q0.pop_front());
            if (f1 && q1.size() > 0) void'(q1.pop_front());
            if (q0.size() > 0) begin
                s0_valid_in = 1'b1;
                s0_data_in  = q0[0].data;
                s0_last_in  = q0[0].last;
            end else begin
                s0_valid_in = 1'b0;
                s0_data_in  = '0;
                s0_last_in  = 1'b0;
            end
            if (q1.size() > 0) begin
                s1_valid_in = 1'b1;
                s1_data_in  = q1[0].data;
                s1_last_in  = q1[0].last;
            end else begin
                s1_valid_in = 1'b0;
                s1_data_in  = '0;
                s1_last_in  = 1'b0;
            end
        end
    end

    // Monitor: every beat taken downstream is compared against the head of
    // the scoreboard.
    always @(negedge clk_in) begin
        if (m_valid_out === 1'b1 && m_ready_in === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got data 0x%0h src %0d, expected no beat",
                         m_data_out, m_src_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("out_data", {24'd0, m_data_out}, {24'd0, e.data});
                checkOutput("out_last", {31'd0, m_last_out}, {31'd0, e.last});
                checkOutput("out_src",  {31'd0, m_src_out},  {31'd0, e.src});
            end
            pop_cycles.push_back(cycle);
            pop_count++;
        end
    end

    // While channel 0 holds its packet lock, channel 1 must never see ready.
    // The watch ends at the negedge where channel 0's last beat is accepted.
    always @(negedge clk_in) begin
        if (lock_phase) begin
            checkOutput("lock_s1_ready", {31'd0, s1_ready_out}, 32'd0);
            if (s0_valid_in === 1'b1 && s0_ready_out === 1'b1 && s0_last_in === 1'b1)
                lock_phase = 1'b0;
        end
    end

    // Watchdog: the run must always end on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        int base;

        m_ready_in = 1'b1;
        rst_n_in   = 1'b0;

        // Reset with both channels requesting; then single-beat alternation.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'(8'hA0 + i), 1'b1);
            applyStimulus(1, 8'(8'hB0 + i), 1'b1);
            expectBeat(8'(8'hA0 + i), 1'b1, 1'b0);
            expectBeat(8'(8'hB0 + i), 1'b1, 1'b1);
        end
        repeat (2) begin
            @(negedge clk_in);
            checkOutput("rst_m_valid",  {31'd0, m_valid_out},  32'd0);
            checkOutput("rst_m_data",   {24'd0, m_data_out},   32'd0);
            checkOutput("rst_s0_ready", {31'd0, s0_ready_out}, 32'd0);
            checkOutput("rst_s1_ready", {31'd0, s1_ready_out}, 32'd0);
        end
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b1;
        base = pop_count;
        waitDrain("alternation", 60);
        if (pop_cycles.size() >= base + 8)
            checkOutput("alt_throughput", pop_cycles[base + 7] - pop_cycles[base], 32'd7);
        checkIdle("alt_idle");

        // Packet lock: ch0 3-beat packet, ch1 waiting with a single beat.
        @(posedge clk_in);
        #2;
        lock_phase = 1'b1;
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h12, 1'b0);
        applyStimulus(0, 8'h13, 1'b1);
        applyStimulus(1, 8'h21, 1'b1);
        expectBeat(8'h11, 1'b0, 1'b0);
        expectBeat(8'h12, 1'b0, 1'b0);
        expectBeat(8'h13, 1'b1, 1'b0);
        expectBeat(8'h21, 1'b1, 1'b1);
        waitDrain("lock", 40);
        checkOutput("lock_released", {31'd0, lock_phase}, 32'd0);
        checkIdle("lock_idle");

        // Backpressure mid-packet: 43 is held in the output register.
        @(posedge clk_in);
        #2;
        base = pop_count;
        applyStimulus(0, 8'h41, 1'b0);
        applyStimulus(0, 8'h42, 1'b0);
        applyStimulus(0, 8'h43, 1'b0);
        applyStimulus(0, 8'h44, 1'b1);
        applyStimulus(1, 8'h51, 1'b1);
        expectBeat(8'h41, 1'b0, 1'b0);
        expectBeat(8'h42, 1'b0, 1'b0);
        expectBeat(8'h43, 1'b0, 1'b0);
        expectBeat(8'h44, 1'b1, 1'b0);
        expectBeat(8'h51, 1'b1, 1'b1);
        waitPops("bp_start", base + 2, 40);
        @(posedge clk_in);
        #2;
        m_ready_in = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            checkOutput("bp_valid",    {31'd0, m_valid_out},  32'd1);
            checkOutput("bp_data",     {24'd0, m_data_out},   32'h43);
            checkOutput("bp_last",     {31'd0, m_last_out},   32'd0);
            checkOutput("bp_src",      {31'd0, m_src_out},    32'd0);
            checkOutput("bp_s0_ready", {31'd0, s0_ready_out}, 32'd0);
            checkOutput("bp_s1_ready", {31'd0, s1_ready_out}, 32'd0);
        end
        @(posedge clk_in);
        #2;
        m_ready_in = 1'b1;
        waitDrain("backpressure", 40);
        checkIdle("bp_idle");

        // Single requester on ch1 while rr_ptr favours ch0.
        @(posedge clk_in);
        #2;
        base = pop_count;
        applyStimulus(1, 8'h31, 1'b1);
        applyStimulus(1, 8'h32, 1'b1);
        expectBeat(8'h31, 1'b1, 1'b1);
        expectBeat(8'h32, 1'b1, 1'b1);
        waitDrain("single", 40);
        if (pop_cycles.size() >= base + 2)
            checkOutput("single_throughput", pop_cycles[base + 1] - pop_cycles[base], 32'd1);
        checkIdle("single_idle");

        // Reset mid-packet.
        // Before the reset, rr_ptr points at ch1 and ch1 is locked. After
        // the reset, ch0 must still win first.
        @(posedge clk_in);
        #2;
        base = pop_count;
        applyStimulus(0, 8'h5A, 1'b1);
        applyStimulus(1, 8'h61, 1'b0);
        applyStimulus(1, 8'h62, 1'b0);
        applyStimulus(1, 8'h63, 1'b0);
        applyStimulus(1, 8'h64, 1'b1);
        expectBeat(8'h5A, 1'b1, 1'b0);
        expectBeat(8'h61, 1'b0, 1'b1);
        expectBeat(8'h62, 1'b0, 1'b1);
        expectBeat(8'h63, 1'b0, 1'b1);
        waitPops("mid_rst_start", base + 3, 40);
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        @(posedge clk_in);
        #2;
        checkOutput("mid_rst_outstanding", exp_q.size(), 32'd0);
        exp_q.delete();
        q0.delete();
        q1.delete();
        repeat (2) begin
            @(negedge clk_in);
            checkOutput("mid_rst_m_valid",  {31'd0, m_valid_out},  32'd0);
            checkOutput("mid_rst_s0_ready", {31'd0, s0_ready_out}, 32'd0);
            checkOutput("mid_rst_s1_ready", {31'd0, s1_ready_out}, 32'd0);
        end
        @(posedge clk_in);
        #2;
        applyStimulus(0, 8'h70, 1'b1);
        applyStimulus(1, 8'h80, 1'b1);
        expectBeat(8'h70, 1'b1, 1'b0);
        expectBeat(8'h80, 1'b1, 1'b1);
        rst_n_in = 1'b1;
        waitDrain("post_rst", 40);
        checkIdle("post_rst_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_merge_2to1_rr.md
Name: stream_merge_2to1_rr

Overview:
- Two-input, one-output packet stream merger; the counterpart of the team's 1-to-2 demux stage.
- Recombines two valid/ready streams into one. Round-robin arbitration is done per packet.
- A granted source stays locked until its packet's last beat is accepted, so packets are never interleaved.
- The output is registered. Sits upstream of any single-lane consumer fed from split paths.

Parameters:
- DATA_W, 8, width of the data payload on every channel.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  reset; synchronous, active-low.
- s0_data_in  input  DATA_W  channel 0 payload.
- s0_valid_in  input  1  channel 0 beat valid.
- s0_last_in  input  1  channel 0 final beat of packet.
- s0_ready_out  output  1  channel 0 beat accepted this cycle when high with s0_valid_in.
- s1_data_in  input  DATA_W  channel 1 payload.
- s1_valid_in  input  1  channel 1 beat valid.
- s1_last_in  input  1  channel 1 final beat of packet.
- s1_ready_out  output  1  channel 1 accept strobe.
- m_data_out  output  DATA_W  merged payload, registered.
- m_valid_out  output  1  merged beat valid, registered.
- m_last_out  output  1  merged last flag, registered.
- m_src_out  output  1  source channel of current output beat (0/1), registered.
- m_ready_in  input  1  downstream accepts beat.

Behaviour:
- Clock and reset: single clock clk_in; reset is synchronous and active-low (rst_n_in).
- Reset state (rst_n_in=0 at a rising edge):
  - m_valid_out=0, m_data_out=0, m_last_out=0, m_src_out=0.
  - FSM=IDLE, rr_ptr=0 (channel 0 favoured).
  - Reset mid-packet abandons the lock and discards any held output beat.
- Load enable: ld = !m_valid_out || m_ready_in (combinational). The output register loads only when ld=1. Otherwise m_* hold stable, with no change while m_valid_out=1 and m_ready_in=0.
- FSM states: IDLE (no packet open), LOCK0, LOCK1.
- Grant in IDLE:
  - Both valid: grant = rr_ptr.
  - Only one valid: grant = that channel.
  - None valid: no grant.
- Grant in LOCKg: grant = g regardless of the other channel's valid.
- Ready generation: sX_ready_out = ld && (grant==X) (combinational). The non-granted channel's ready = 0 at all times.
- Accept: sX_valid_in && sX_ready_out.
  - On accept, next edge: m_data_out<=sX_data_in, m_last_out<=sX_last_in, m_src_out<=X, m_valid_out<=1.
  - If ld=1 and no accept: m_valid_out<=0.
- Transitions:
  - IDLE→LOCKX on accept with last=0.
  - IDLE→IDLE on accept with last=1 (single-beat packet).
  - LOCKX→IDLE on accept with last=1.
  - Any state holds otherwise.
- rr_ptr update: only on acceptance of a beat with last=1 from channel X; then rr_ptr <= ~X. Not updated on non-last beats or on idle cycles.
- Latency and throughput: one cycle from input accept to m_valid_out. Sustained throughput 1 beat/cycle when m_ready_in=1 continuously.
- Output backpressure: with m_ready_in=0 and m_valid_out=1, both readies are 0 and no state changes.
- Simultaneous events:
  - Output beat taken and new beat accepted in the same cycle is legal; the register is overwritten with no bubble.
  - Valid rising on the non-granted channel during a lock is ignored until the lock releases.
- Widths: no arithmetic on data. Data passes unmodified, zero-extended never, width exactly DATA_W.

Test Plan:
- Reset: hold rst_n_in=0 for 2 cycles with both valids high → m_valid_out=0, s0_ready_out=s1_ready_out=0 during reset. First grant after release goes to ch0.
- Single-beat alternation: both channels present continuous single-beat packets (last=1), ch0 data 0xA0.., ch1 0xB0.., m_ready_in=1 → output sequence A0,B0,A1,B1… and m_src_out toggles 0,1,0,1. One beat/cycle.
- Packet lock: ch0 sends 3-beat packet 0x11,0x12,0x13(last), ch1 valid throughout with 0x21(last) → output 11,12,13,21. s1_ready_out=0 until 0x13 accepted.
- Backpressure: mid-packet drop m_ready_in for 4 cycles → m_data_out/m_last_out/m_src_out stable, both readies 0. Resume yields the next beat with no loss or duplication.
- Single requester: only ch1 valid with 1-beat packets 0x31,0x32, rr_ptr=0 → both granted to ch1, no stall. rr_ptr becomes 0 after each.
- Reset mid-packet: assert reset after 2 beats of a 4-beat ch1 packet → FSM IDLE, m_valid_out=0. Then with both valid, ch0 granted first.
